// File: rtl/edge_pulse_gen.sv
// edge_pulse_gen: per-channel edge detector driving a fixed-length pulse.
// Macro EDGE_PULSE_SYNC_EN adds a two-flop input synchronizer per channel.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   din[SIZE]           level inputs, one per channel
//   edge_mode[2]        00 rise, 01 fall, 10 both, 11 off
//   pulse_len[LEN_W]    pulse length in cycles (0 acts as 1)
//   retrig              edge during a pulse restarts it
//   clr_missed          clear all sticky missed flags
//   dout[SIZE]          registered pulse outputs
//   missed[SIZE]        sticky: edge dropped during a pulse
//   busy                registered OR of dout
module edge_pulse_gen #(
   parameter int SIZE  = 8,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [SIZE-1:0]  din,
   input  logic [1:0]       edge_mode,
   input  logic [LEN_W-1:0] pulse_len,
   input  logic             retrig,
   input  logic             clr_missed,
   output logic [SIZE-1:0]  dout,
   output logic [SIZE-1:0]  missed,
   output logic             busy
);

   typedef enum logic {IDLE = 1'b0, PULSE = 1'b1} state_t;

   logic [SIZE-1:0] src;

`ifdef EDGE_PULSE_SYNC_EN
   // s/h are first loaded once the synchronizer holds real samples
   localparam logic [1:0] ARM_N = 2'd3;
   logic [SIZE-1:0] sy1, sy2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sy1 <= '0;
         sy2 <= '0;
      end else begin
         sy1 <= din;
         sy2 <= sy1;
      end
   end

   assign src = sy2;
`else
   localparam logic [1:0] ARM_N = 2'd1;

   assign src = din;
`endif

   logic [1:0]      arm_cnt;
   logic            armed;
   logic [SIZE-1:0] s, h;
   logic [SIZE-1:0] det;

   assign armed = (arm_cnt == ARM_N);

   // First real sample loads both s and h so a static level is not an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_cnt <= '0;
         s       <= '0;
         h       <= '0;
      end else begin
         if (!armed) arm_cnt <= arm_cnt + 2'd1;
         if (arm_cnt == ARM_N - 2'd1) begin
            s <= src;
            h <= src;
         end else if (armed) begin
            s <= src;
            h <= s;
         end
      end
   end

   always_comb begin
      det = '0;
      unique case (edge_mode)
         2'b00: det = s & ~h;
         2'b01: det = ~s & h;
         2'b10: det = s ^ h;
         2'b11: det = '0;
      endcase
      if (!armed) det = '0;
   end

   logic [LEN_W-1:0] reload;

   assign reload = (pulse_len == '0) ? '0 : pulse_len - LEN_W'(1);

   state_t           state_q [SIZE];
   state_t           state_d [SIZE];
   logic [LEN_W-1:0] cnt_q   [SIZE];
   logic [LEN_W-1:0] cnt_d   [SIZE];
   logic [SIZE-1:0]  miss_set;
   logic [SIZE-1:0]  pulse_d;

   always_comb begin
      miss_set = '0;
      pulse_d  = '0;
      for (int i = 0; i < SIZE; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         pulse_d[i] = (state_q[i] == PULSE);
         unique case (state_q[i])
            IDLE: begin
               if (det[i]) begin
                  state_d[i] = PULSE;
                  cnt_d[i]   = reload;
               end
            end
            PULSE: begin
               if (det[i] && retrig) begin
                  cnt_d[i] = reload;
               end else begin
                  miss_set[i] = det[i];
                  if (cnt_q[i] == '0) state_d[i] = IDLE;
                  else cnt_d[i] = cnt_q[i] - LEN_W'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SIZE; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
         dout   <= '0;
         missed <= '0;
         busy   <= 1'b0;
      end else begin
         for (int i = 0; i < SIZE; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         // dout trails the FSM state by one register stage
         dout   <= pulse_d;
         busy   <= |pulse_d;
         // a new miss in the same cycle as a clear is kept
         missed <= (missed & ~{SIZE{clr_missed}}) | miss_set;
      end
   end

endmodule

// File: tb/tb_edge_pulse_gen.sv
// tb_edge_pulse_gen: directed scoreboard bench for edge_pulse_gen.
// Expected dout/busy per cycle are queued as stimulus is applied.
module tb_edge_pulse_gen;

   localparam int SIZE  = 8;
   localparam int LEN_W = 4;
`ifdef EDGE_PULSE_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic [SIZE-1:0]  din;
   logic [1:0]       edge_mode;
   logic [LEN_W-1:0] pulse_len;
   logic             retrig;
   logic             clr_missed;
   logic [SIZE-1:0]  dout;
   logic [SIZE-1:0]  missed;
   logic             busy;

   edge_pulse_gen #(.SIZE(SIZE), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .edge_mode (edge_mode),
      .pulse_len (pulse_len),
      .retrig    (retrig),
      .clr_missed(clr_missed),
      .dout      (dout),
      .missed    (missed),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int              cyc;
      logic [SIZE-1:0] d;
   } item_t;

   item_t           q[$];
   logic [SIZE-1:0] exp_d [int];
   int              sched_to;
   int              checks = 0;
   int              errors = 0;

   always @(negedge clk) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
         item_t it;
         it = q.pop_front();
         checks++;
         assert (dout === it.d) else begin
            errors++;
            $error("FAIL dout cyc=%0d got=%h exp=%h", cyc, dout, it.d);
         end
         checks++;
         assert (busy === (|it.d)) else begin
            errors++;
            $error("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, |it.d);
         end
      end
   end

   task automatic check(input string tag, input logic [SIZE-1:0] got,
                        input logic [SIZE-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic exp_pulse(input int st, input int len,
                            input logic [SIZE-1:0] m);
      for (int k = 0; k < len; k++) begin
         if (exp_d.exists(st + k)) exp_d[st + k] = exp_d[st + k] | m;
         else exp_d[st + k] = m;
      end
   endtask

   task automatic run(input int n);
      item_t it;
      for (int t = sched_to + 1; t <= cyc + n; t++) begin
         it.cyc = t;
         it.d   = exp_d.exists(t) ? exp_d[t] : '0;
         q.push_back(it);
      end
      sched_to = cyc + n;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Asynchronous reset mid-cycle: outputs must clear at once
   task automatic reset_assert();
      #1;
      rst_n = 1'b0;
      while (q.size() > 0 && q[q.size()-1].cyc >= cyc) void'(q.pop_back());
      exp_d.delete();
      sched_to = cyc - 1;
      #1;
      check("arst_dout", dout, '0);
      check("arst_busy", {7'b0, busy}, '0);
      check("arst_missed", missed, '0);
   endtask

   initial begin
      rst_n      = 1'b0;
      din        = '0;
      edge_mode  = 2'b00;
      pulse_len  = 4'd3;
      retrig     = 1'b0;
      clr_missed = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_dout", dout, '0);
      check("rst_missed", missed, '0);
      check("rst_busy", {7'b0, busy}, '0);
      rst_n    = 1'b1;
      sched_to = cyc - 1;
      run(6);

      // single rising edge, length 3
      din[0] = 1'b1;
      exp_pulse(cyc + 1 + LAT, 3, 8'h01);
      run(10);
      din[0] = 1'b0;
      run(6);

      // disabled mode, then both-edge mode with length 0
      edge_mode = 2'b11;
      din[2]    = 1'b1;
      run(6);
      edge_mode = 2'b10;
      pulse_len = 4'd0;
      run(2);
      din[2] = 1'b0;
      exp_pulse(cyc + 1 + LAT, 1, 8'h04);
      run(8);
      din[2] = 1'b1;
      exp_pulse(cyc + 1 + LAT, 1, 8'h04);
      run(8);

      // retrigger: second edge one cycle into the pulse
      edge_mode = 2'b00;
      pulse_len = 4'd5;
      retrig    = 1'b1;
      din[1]    = 1'b1;
      exp_pulse(cyc + 1 + LAT, 7, 8'h02);
      run(1);
      din[1] = 1'b0;
      run(1);
      din[1] = 1'b1;
      run(12);
      check("retrig_missed", missed, '0);
      din[1] = 1'b0;
      run(4);

      // same pattern without retrigger: pulse 5, missed set
      retrig = 1'b0;
      din[1] = 1'b1;
      exp_pulse(cyc + 1 + LAT, 5, 8'h02);
      run(1);
      din[1] = 1'b0;
      run(1);
      din[1] = 1'b1;
      run(8);
      check("missed_set", missed, 8'h02);
      run(2);
      check("missed_sticky", missed, 8'h02);
      clr_missed = 1'b1;
      run(1);
      clr_missed = 1'b0;
      check("missed_clr", missed, '0);
      din[1] = 1'b0;
      run(4);

      // static high through reset release, then all channels fall
      pulse_len = 4'd3;
      reset_assert();
      din = 8'hFF;
      run(2);
      rst_n = 1'b1;
      run(8);
      edge_mode = 2'b01;
      din       = 8'h00;
      exp_pulse(cyc + 1 + LAT, 3, 8'hFF);
      run(8);

      // reset mid-pulse, no resumption
      edge_mode = 2'b00;
      pulse_len = 4'd8;
      din[3]    = 1'b1;
      exp_pulse(cyc + 1 + LAT, 8, 8'h08);
      run(1);
      din[3] = 1'b0;
      run(1);
      din[3] = 1'b1;
      run(LAT + 2);
      check("pre_rst_missed", missed, 8'h08);
      check("pre_rst_dout", dout, 8'h08);
      reset_assert();
      run(2);
      rst_n = 1'b1;
      run(14);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
